wb_stage: RTL and testbench

// - Writeback end of the MEM/WB pipeline interface: consumes the Wr_* bundle, selects result, writes GPRs.
// - Holds the 32x32 register file; serves two ID-stage read ports with same-cycle write bypass.
// - Suppresses writes of overflowing instructions, latches EPC/exception flag, counts retired instructions.

---
 rtl/wb_stage_pkg.sv | 21 ++
 rtl/wb_stage_if.sv | 19 +
 rtl/wb_stage_regfile.sv | 46 ++++
 rtl/wb_stage.sv | 85 ++++++++
 tb/tb_wb_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
package wb_stage_pkg;

  // Writeback result select encodings.
  typedef enum logic [1:0] {
    WbSelAlu  = 2'd0,
    WbSelMem  = 2'd1,
    WbSelLink = 2'd2,
    WbSelRsvd = 2'd3
  } wb_sel_e;

  localparam logic [4:0] RegZero = 5'd0;

  // Return address of a linking instruction: next word, as a byte address.
  function automatic logic [31:0] link_addr(input logic [29:0] pc);
    logic [29:0] next_pc;
    next_pc = pc + 30'd1;
    return {next_pc, 2'b00};
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register bundle as seen by the writeback stage.
interface wb_stage_if;
  logic [29:0] Wr_pc;
  logic        Wr_overflow;
  logic [31:0] Wr_memout;
  logic [31:0] Wr_aluout;
  logic [31:0] Wr_ins;
  logic        Wr_RegWr;
  logic [1:0]  Wr_MemtoReg;
  logic [4:0]  Wr_Rw;

  modport master (
    output Wr_pc, Wr_overflow, Wr_memout, Wr_aluout, Wr_ins, Wr_RegWr, Wr_MemtoReg, Wr_Rw
  );

  modport slave (
    input Wr_pc, Wr_overflow, Wr_memout, Wr_aluout, Wr_ins, Wr_RegWr, Wr_MemtoReg, Wr_Rw
  );
endinterface

// File: rtl/wb_stage_regfile.sv
// 32x32 GPR file: one write port, two asynchronous read ports with write bypass.
// Register 0 is hardwired to zero on both reads and writes.
module wb_stage_regfile
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] gpr_q [32];

  // Storage update; entry 0 is only ever cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (we && (waddr == 5'(i))) begin
          gpr_q[i] <= wdata;
        end
      end
    end
  end

  // Read ports: $0 first, then same-cycle bypass of the pending write.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (ra != RegZero) begin
      rdata_a = (we && (ra == waddr)) ? wdata : gpr_q[ra];
    end
    if (rb != RegZero) begin
      rdata_b = (we && (rb == waddr)) ? wdata : gpr_q[rb];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, write suppression on overflow, exception
// latch (first fault wins) and retired-instruction counter.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] NOP_INS = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        wr,
  input  logic [4:0]       Ra,
  input  logic [4:0]       Rb,
  output logic [31:0]      busA,
  output logic [31:0]      busB,
  output logic [31:0]      wb_data,
  output logic             wb_we,
  input  logic             exc_clr,
  output logic             exc_valid,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] retired
);

  wb_sel_e          sel;
  logic             fault;
  logic             exc_valid_q;
  logic [31:0]      epc_q;
  logic [CNT_W-1:0] retired_q;

  assign sel = wb_sel_e'(wr.Wr_MemtoReg);

  // Result mux and effective write enable.
  always_comb begin
    wb_data = wr.Wr_aluout;
    unique case (sel)
      WbSelAlu:  wb_data = wr.Wr_aluout;
      WbSelMem:  wb_data = wr.Wr_memout;
      WbSelLink: wb_data = link_addr(wr.Wr_pc);
      WbSelRsvd: wb_data = wr.Wr_aluout;
    endcase
    fault = wr.Wr_overflow & wr.Wr_RegWr;
    wb_we = wr.Wr_RegWr & ~wr.Wr_overflow & (wr.Wr_Rw != RegZero);
  end

  wb_stage_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wr.Wr_Rw),
    .wdata   (wb_data),
    .ra      (Ra),
    .rb      (Rb),
    .rdata_a (busA),
    .rdata_b (busB)
  );

  // Exception latch: epc captured only when no fault is pending or it is being cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_valid_q <= 1'b0;
      epc_q       <= '0;
    end else if (fault) begin
      exc_valid_q <= 1'b1;
      if (!exc_valid_q || exc_clr) begin
        epc_q <= {wr.Wr_pc, 2'b00};
      end
    end else if (exc_clr) begin
      exc_valid_q <= 1'b0;
    end
  end

  // Retire counter: bubbles and faulting instructions are not counted; wraps freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if ((wr.Wr_ins != NOP_INS) && !fault) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign exc_valid = exc_valid_q;
  assign epc       = epc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed checks of wb_stage against a behavioural model.
module tb_wb_stage;

  localparam int unsigned CW = 4;
  localparam logic [31:0] NOP = 32'd0;

  logic          clk;
  logic          rst;
  logic [4:0]    Ra, Rb;
  logic [31:0]   busA, busB, wb_data, epc;
  logic          wb_we, exc_clr, exc_valid;
  logic [CW-1:0] retired;

  wb_stage_if bus ();

  wb_stage #(
    .CNT_W   (CW),
    .NOP_INS (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (bus),
    .Ra        (Ra),
    .Rb        (Rb),
    .busA      (busA),
    .busB      (busB),
    .wb_data   (wb_data),
    .wb_we     (wb_we),
    .exc_clr   (exc_clr),
    .exc_valid (exc_valid),
    .epc       (epc),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [31:0] m_gpr [32];
  logic        m_exc;
  logic [31:0] m_epc;
  int          m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_exc = 1'b0;
    m_epc = '0;
    m_ret = 0;
  endtask

  task automatic drive(input logic regwr, input logic ovf, input logic [1:0] m2r,
                       input logic [4:0] rw, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [29:0] pc, input logic [31:0] ins,
                       input logic [4:0] ra_v, input logic [4:0] rb_v, input logic clr);
    bus.Wr_RegWr    = regwr;
    bus.Wr_overflow = ovf;
    bus.Wr_MemtoReg = m2r;
    bus.Wr_Rw       = rw;
    bus.Wr_aluout   = alu;
    bus.Wr_memout   = mem;
    bus.Wr_pc       = pc;
    bus.Wr_ins      = ins;
    Ra              = ra_v;
    Rb              = rb_v;
    exc_clr         = clr;
  endtask

  // Called just after a negedge with inputs driven; checks combinational
  // outputs, crosses the posedge, then checks state.
  task automatic run_cycle();
    logic [31:0] res, exp_a, exp_b;
    logic        we, flt;
    #1;
    case (bus.Wr_MemtoReg)
      2'd1:    res = bus.Wr_memout;
      2'd2:    res = {bus.Wr_pc + 30'd1, 2'b00};
      default: res = bus.Wr_aluout;
    endcase
    we    = bus.Wr_RegWr && !bus.Wr_overflow && (bus.Wr_Rw != 0);
    exp_a = (Ra == 0) ? 32'd0 : ((we && Ra == bus.Wr_Rw) ? res : m_gpr[Ra]);
    exp_b = (Rb == 0) ? 32'd0 : ((we && Rb == bus.Wr_Rw) ? res : m_gpr[Rb]);
    check("wb_data", wb_data, res);
    check("wb_we", 32'(wb_we), 32'(we));
    check("busA", busA, exp_a);
    check("busB", busB, exp_b);
    @(posedge clk);
    #1;
    if (we) m_gpr[bus.Wr_Rw] = res;
    flt = bus.Wr_overflow && bus.Wr_RegWr;
    if (flt) begin
      if (!m_exc || exc_clr) m_epc = {bus.Wr_pc, 2'b00};
      m_exc = 1'b1;
    end else if (exc_clr) begin
      m_exc = 1'b0;
    end
    if (bus.Wr_ins != NOP && !flt) m_ret = (m_ret + 1) % (1 << CW);
    check("exc_valid", 32'(exc_valid), 32'(m_exc));
    check("epc", epc, m_epc);
    check("retired", 32'(retired), 32'(m_ret));
    @(negedge clk);
  endtask

  // Asynchronous reset pulse away from any edge, with a full read sweep while held.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 30'd0, NOP, 5'd0, 5'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_exc_valid", 32'(exc_valid), 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i);
      Rb = 5'(31 - i);
      #0.1;
      check("rst_busA", busA, 32'd0);
      check("rst_busB", busB, 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 30'd0, NOP, 5'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_reset();

    // Write with same-cycle bypass, then the stored value.
    drive(1'b1, 1'b0, 2'd0, 5'd5, 32'h1234_5678, 32'd0, 30'h1, 32'h1, 5'd5, 5'd5, 1'b0);
    #1 check("bypass_busA", busA, 32'h1234_5678);
    run_cycle();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 30'h2, NOP, 5'd5, 5'd0, 1'b0);
    #1 check("stored_busA", busA, 32'h1234_5678);
    run_cycle();

    // $0 is never written nor bypassed.
    drive(1'b1, 1'b0, 2'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 30'h3, 32'h3, 5'd0, 5'd0, 1'b0);
    #1 check("zero_we", 32'(wb_we), 32'd0);
    run_cycle();

    // Link results, including PC wrap.
    drive(1'b1, 1'b0, 2'd2, 5'd31, 32'hAAAA_AAAA, 32'd0, 30'h3FFF_FFFF, 32'h4, 5'd0, 5'd0, 1'b0);
    run_cycle();
    drive(1'b1, 1'b0, 2'd2, 5'd30, 32'hAAAA_AAAA, 32'd0, 30'h100, 32'h5, 5'd0, 5'd0, 1'b0);
    run_cycle();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 30'h6, NOP, 5'd31, 5'd30, 1'b0);
    #1 check("link_wrap", busA, 32'h0000_0000);
    check("link_404", busB, 32'h0000_0404);
    run_cycle();

    // Overflow suppresses the write and latches epc; the first fault wins.
    drive(1'b1, 1'b0, 2'd0, 5'd8, 32'h88, 32'd0, 30'h3F, 32'h7, 5'd0, 5'd0, 1'b0);
    run_cycle();
    drive(1'b1, 1'b1, 2'd0, 5'd8, 32'hDEAD_BEEF, 32'd0, 30'h40, 32'h8, 5'd8, 5'd0, 1'b0);
    run_cycle();
    check("ovf_exc", 32'(exc_valid), 32'd1);
    check("ovf_epc", epc, 32'h100);
    drive(1'b1, 1'b1, 2'd0, 5'd8, 32'hDEAD_BEEF, 32'd0, 30'h50, 32'h9, 5'd8, 5'd0, 1'b0);
    run_cycle();
    check("ovf_first_wins", epc, 32'h100);
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 30'h51, NOP, 5'd8, 5'd0, 1'b1);
    #1 check("ovf_gpr8", busA, 32'h88);
    run_cycle();
    check("exc_clr", 32'(exc_valid), 32'd0);

    // Retire accounting: 3 valid, 2 bubbles, 1 fault; then wrap.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ins_v;
      logic        ovf_v;
      ins_v = (i == 1 || i == 3) ? NOP : 32'(i + 16);
      ovf_v = (i == 4);
      drive(1'b1, ovf_v, 2'd0, 5'd9, 32'(i), 32'd0, 30'(i), ins_v, 5'd9, 5'd0, 1'b0);
      run_cycle();
    end
    check("retired_3", 32'(retired), 32'd3);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 30'(i), 32'hC0DE, 5'd0, 5'd0, 1'b1);
      run_cycle();
    end
    check("retired_max", 32'(retired), 32'd15);
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 30'h7, 32'hC0DE, 5'd0, 5'd0, 1'b0);
    run_cycle();
    check("retired_wrap", 32'(retired), 32'd0);

    // Randomized traffic, with one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      logic regwr, ovf;
      regwr = 1'($urandom_range(0, 3) != 0);
      ovf   = regwr && ($urandom_range(0, 7) == 0);
      drive(regwr, ovf, 2'($urandom), 5'($urandom), $urandom, $urandom, 30'($urandom),
            ($urandom_range(0, 3) == 0) ? NOP : $urandom, 5'($urandom), 5'($urandom),
            1'($urandom_range(0, 7) == 0));
      run_cycle();
      if (n == 200) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
